// File: rtl/sgd_server_recv_mc.sv
// Multi-channel receive demux for the SGD parameter server.
// Identifies the sending worker by source IP and steers beats round-robin
// into per-(worker, engine) FIFOs. All FIFOs are then drained in lock-step
// to give one aligned set of per-bank dot products per round.
//
// write fsm
//   state   | meaning
//   W_IDLE  | waiting for metadata; zero-length metadata is discarded
//   W_JUDGE | one cycle to act on the latched IP lookup
//   W_RECV  | steering beats of a known worker into its FIFOs
//   W_DROP  | swallowing beats of an unknown sender until last
// read fsm
//   state   | meaning
//   R_IDLE  | waiting until every FIFO holds at least one entry
//   R_POP   | pop all FIFOs together for one cycle
//   R_WAIT  | rd_gap down-counter running before the next round
module sgd_server_recv_mc #(
   parameter int WORKER_NUM      = 2,
   parameter int ENGINE_NUM      = 2,
   parameter int NUM_OF_BANKS    = 8,
   parameter int DATA_W          = 512,
   parameter int FIFO_DEPTH_BITS = 6
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic [WORKER_NUM*32-1:0]                      ip_table,
   input  logic [3:0]                                    rd_gap,
   input  logic                                          s_axis_rx_metadata_valid,
   output logic                                          s_axis_rx_metadata_ready,
   input  logic [87:0]                                   s_axis_rx_metadata_data,
   input  logic                                          s_axis_rx_data_valid,
   output logic                                          s_axis_rx_data_ready,
   input  logic [DATA_W-1:0]                             s_axis_rx_data_data,
   input  logic                                          s_axis_rx_data_last,
   output logic [WORKER_NUM*ENGINE_NUM*NUM_OF_BANKS*32-1:0] dot_product_signed,
   output logic [WORKER_NUM*ENGINE_NUM*NUM_OF_BANKS-1:0]    dot_product_signed_valid,
   output logic [WORKER_NUM*16-1:0]                      session_id,
   output logic [31:0]                                   drop_pkt_cnt,
   output logic                                          overflow
);

   localparam int CH    = WORKER_NUM * ENGINE_NUM;
   localparam int PAY_W = NUM_OF_BANKS * 32;
   localparam int DEPTH = 2 ** FIFO_DEPTH_BITS;
   localparam int CH_W  = (CH > 1) ? $clog2(CH) : 1;
   localparam int BI_W  = (ENGINE_NUM > 1) ? $clog2(ENGINE_NUM) : 1;
   localparam int WI_W  = (WORKER_NUM > 1) ? $clog2(WORKER_NUM) : 1;
   localparam int CNT_W = FIFO_DEPTH_BITS + 1;

   typedef enum logic [1:0] {W_IDLE, W_JUDGE, W_RECV, W_DROP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_POP, R_WAIT} r_state_t;

   w_state_t w_state, w_next;
   r_state_t r_state, r_next;

   logic [BI_W-1:0]            beat_idx;
   logic                       match_hit_q;
   logic [WI_W-1:0]            match_idx_q;
   logic [15:0]                session_q;
   logic [15:0]                session_arr [WORKER_NUM];
   logic                       lookup_hit;
   logic [WI_W-1:0]            lookup_idx;
   logic [CH_W-1:0]            target_ch;
   logic                       meta_fire, data_fire, meta_nonzero;

   logic                       push_q;
   logic [CH_W-1:0]            push_ch;
   logic [PAY_W-1:0]           push_data;
   logic [CH-1:0]              push_ok, fifo_ne, almost_full;
   logic                       pop, pop_d1;
   logic [FIFO_DEPTH_BITS-1:0] wr_ptr [CH];
   logic [FIFO_DEPTH_BITS-1:0] rd_ptr [CH];
   logic [CNT_W-1:0]           count  [CH];
   logic [PAY_W-1:0]           mem    [CH][DEPTH];
   logic [PAY_W-1:0]           rd_data [CH];
   logic [3:0]                 gap_cnt;

   // Port, close flag and upper data bits carry nothing this block needs.
   logic unused_meta;
   assign unused_meta = ^s_axis_rx_metadata_data[87:64];
   generate
      if (DATA_W > PAY_W) begin : g_unused
         logic unused_data;
         assign unused_data = ^s_axis_rx_data_data[DATA_W-1:PAY_W];
      end
   endgenerate

   assign meta_fire    = s_axis_rx_metadata_valid & s_axis_rx_metadata_ready;
   assign data_fire    = s_axis_rx_data_valid & s_axis_rx_data_ready;
   assign meta_nonzero = (s_axis_rx_metadata_data[31:16] != 16'd0);
   assign target_ch    = CH_W'(match_idx_q) * CH_W'(ENGINE_NUM) + CH_W'(beat_idx);
   assign pop          = (r_state == R_POP);

   // IP lookup; scanning downward leaves the lowest matching index.
   always_comb begin
      lookup_hit = 1'b0;
      lookup_idx = '0;
      for (int w = WORKER_NUM - 1; w >= 0; w--) begin
         if (ip_table[w*32 +: 32] == s_axis_rx_metadata_data[63:32]) begin
            lookup_hit = 1'b1;
            lookup_idx = WI_W'(w);
         end
      end
   end

   // FIFO status flags and push qualification.
   always_comb begin
      for (int c = 0; c < CH; c++) begin
         fifo_ne[c]     = (count[c] != '0);
         almost_full[c] = (count[c] >= CNT_W'(DEPTH - 2));
         push_ok[c]     = push_q && (push_ch == CH_W'(c)) &&
                          ((count[c] != CNT_W'(DEPTH)) || pop);
      end
   end

   always_comb begin
      for (int w = 0; w < WORKER_NUM; w++) session_id[w*16 +: 16] = session_arr[w];
   end

   // Write FSM state register.
   always_ff @(posedge clk) begin
      if (rst) w_state <= W_IDLE;
      else     w_state <= w_next;
   end

   // Write FSM next state and handshake outputs.
   always_comb begin
      w_next                   = w_state;
      s_axis_rx_metadata_ready = 1'b0;
      s_axis_rx_data_ready     = 1'b0;
      case (w_state)
         W_IDLE: begin
            s_axis_rx_metadata_ready = 1'b1;
            if (s_axis_rx_metadata_valid && meta_nonzero) w_next = W_JUDGE;
         end
         W_JUDGE: w_next = match_hit_q ? W_RECV : W_DROP;
         W_RECV: begin
            s_axis_rx_data_ready = ~almost_full[target_ch];
            if (s_axis_rx_data_valid && s_axis_rx_data_ready && s_axis_rx_data_last)
               w_next = W_IDLE;
         end
         W_DROP: begin
            s_axis_rx_data_ready = 1'b1;
            if (s_axis_rx_data_valid && s_axis_rx_data_last) w_next = W_IDLE;
         end
         default: w_next = W_IDLE;
      endcase
   end

   // Write-side datapath: metadata latch, session table, beat steering, drop count.
   always_ff @(posedge clk) begin
      if (rst) begin
         beat_idx     <= '0;
         match_hit_q  <= 1'b0;
         match_idx_q  <= '0;
         session_q    <= '0;
         drop_pkt_cnt <= '0;
         push_q       <= 1'b0;
         push_ch      <= '0;
         push_data    <= '0;
         for (int w = 0; w < WORKER_NUM; w++) session_arr[w] <= '0;
      end else begin
         push_q <= 1'b0;
         if (w_state == W_IDLE && meta_fire && meta_nonzero) begin
            session_q   <= s_axis_rx_metadata_data[15:0];
            match_hit_q <= lookup_hit;
            match_idx_q <= lookup_idx;
         end
         if (w_state == W_JUDGE && match_hit_q) session_arr[match_idx_q] <= session_q;
         if (w_state == W_RECV && data_fire) begin
            push_q    <= 1'b1;
            push_ch   <= target_ch;
            push_data <= s_axis_rx_data_data[PAY_W-1:0];
            if (s_axis_rx_data_last || beat_idx == BI_W'(ENGINE_NUM - 1)) beat_idx <= '0;
            else                                                          beat_idx <= beat_idx + BI_W'(1);
         end
         if (w_state == W_DROP && data_fire && s_axis_rx_data_last && drop_pkt_cnt != '1)
            drop_pkt_cnt <= drop_pkt_cnt + 32'd1;
      end
   end

   // FIFO pointers, occupancy and sticky overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow <= 1'b0;
         for (int c = 0; c < CH; c++) begin
            wr_ptr[c] <= '0;
            rd_ptr[c] <= '0;
            count[c]  <= '0;
         end
      end else begin
         for (int c = 0; c < CH; c++) begin
            if (push_q && push_ch == CH_W'(c) && !push_ok[c]) overflow <= 1'b1;
            if (push_ok[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
            if (pop)        rd_ptr[c] <= rd_ptr[c] + 1'b1;
            case ({push_ok[c], pop})
               2'b10:   count[c] <= count[c] + 1'b1;
               2'b01:   count[c] <= count[c] - 1'b1;
               default: count[c] <= count[c];
            endcase
         end
      end
   end

   // FIFO storage with registered read port.
   always_ff @(posedge clk) begin
      for (int c = 0; c < CH; c++) begin
         if (push_ok[c]) mem[c][wr_ptr[c]] <= push_data;
         if (pop)        rd_data[c] <= mem[c][rd_ptr[c]];
      end
   end

   // Read FSM state register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= R_IDLE;
      else     r_state <= r_next;
   end

   // Read FSM next state.
   always_comb begin
      r_next = r_state;
      case (r_state)
         R_IDLE:  if (&fifo_ne) r_next = R_POP;
         R_POP:   r_next = R_WAIT;
         R_WAIT:  if (gap_cnt == 4'd0) r_next = R_IDLE;
         default: r_next = R_IDLE;
      endcase
   end

   // Gap timer, output register and valid strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         gap_cnt                  <= '0;
         pop_d1                   <= 1'b0;
         dot_product_signed       <= '0;
         dot_product_signed_valid <= '0;
      end else begin
         pop_d1                   <= pop;
         dot_product_signed_valid <= {(CH*NUM_OF_BANKS){pop_d1}};
         if (pop_d1) begin
            for (int c = 0; c < CH; c++) dot_product_signed[c*PAY_W +: PAY_W] <= rd_data[c];
         end
         if (pop)                                    gap_cnt <= rd_gap;
         else if (r_state == R_WAIT && gap_cnt != 0) gap_cnt <= gap_cnt - 4'd1;
      end
   end

endmodule

// File: tb/tb_sgd_server_recv_mc.sv
// Bench for sgd_server_recv_mc: directed packet scenarios with random
// payloads, scored against per-channel expectation queues.
module tb_sgd_server_recv_mc;

   localparam int WN = 2, EN = 2, NB = 8, DW = 512, FB = 6;
   localparam int CH = WN * EN, PW = NB * 32;
   localparam logic [31:0] IP0 = 32'h0A000001, IP1 = 32'h0A000002, IPX = 32'hC0A80001;

   logic               clk = 1'b0;
   logic               rst;
   logic [WN*32-1:0]   ip_table;
   logic [3:0]         rd_gap;
   logic               meta_valid, meta_ready;
   logic [87:0]        meta_data;
   logic               data_valid, data_ready, data_last;
   logic [DW-1:0]      data_data;
   logic [CH*PW-1:0]   dot;
   logic [CH*NB-1:0]   dot_valid;
   logic [WN*16-1:0]   session_id;
   logic [31:0]        drop_cnt;
   logic               overflow;

   sgd_server_recv_mc #(.WORKER_NUM(WN), .ENGINE_NUM(EN), .NUM_OF_BANKS(NB),
                        .DATA_W(DW), .FIFO_DEPTH_BITS(FB)) dut (
      .clk(clk), .rst(rst), .ip_table(ip_table), .rd_gap(rd_gap),
      .s_axis_rx_metadata_valid(meta_valid), .s_axis_rx_metadata_ready(meta_ready),
      .s_axis_rx_metadata_data(meta_data),
      .s_axis_rx_data_valid(data_valid), .s_axis_rx_data_ready(data_ready),
      .s_axis_rx_data_data(data_data), .s_axis_rx_data_last(data_last),
      .dot_product_signed(dot), .dot_product_signed_valid(dot_valid),
      .session_id(session_id), .drop_pkt_cnt(drop_cnt), .overflow(overflow));

   always #5 clk = ~clk;

   int n_tests = 0, n_fail = 0;
   int cyc = 0, npulse = 0;
   int pulse_cyc[$];
   logic [PW-1:0] exp_q [CH][$];
   logic [PW-1:0] exp_pay;
   logic [15:0]   exp_sess [WN];
   logic [31:0]   exp_drop;
   int            cur_w, mbeat;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: which worker owns an IP (lowest index wins).
   function automatic int lookup(input logic [31:0] ip);
      for (int w = 0; w < WN; w++) if (ip_table[w*32 +: 32] == ip) return w;
      return -1;
   endfunction

   function automatic logic all_nonempty();
      for (int c = 0; c < CH; c++) if (exp_q[c].size() == 0) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [PW-1:0] rand_pay();
      logic [PW-1:0] r;
      for (int n = 0; n < NB; n++) r[n*32 +: 32] = $urandom();
      return r;
   endfunction

   function automatic logic [PW-1:0] pattern_pay(input int base);
      logic [PW-1:0] r;
      for (int n = 0; n < NB; n++) r[n*32 +: 32] = 32'(base + n + 1);
      return r;
   endfunction

   // Every output pulse must be a full-width strobe carrying the head of each channel queue.
   always @(negedge clk) begin
      if (dot_valid !== '0) begin
         npulse++;
         pulse_cyc.push_back(cyc);
         n_tests++;
         assert (dot_valid === {(CH*NB){1'b1}})
            else begin n_fail++; $error("FAIL valid_all got %h exp all ones", dot_valid); end
         for (int c = 0; c < CH; c++) begin
            n_tests++;
            assert (exp_q[c].size() > 0)
               else begin n_fail++; $error("FAIL pulse_data_avail ch%0d got pulse exp no pulse", c); end
            if (exp_q[c].size() > 0) begin
               exp_pay = exp_q[c].pop_front();
               n_tests++;
               assert (dot[c*PW +: PW] === exp_pay)
                  else begin n_fail++; $error("FAIL dot_ch%0d got %h exp %h", c, dot[c*PW +: PW], exp_pay); end
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      assert (got === exp)
         else begin n_fail++; $error("FAIL %s got %0h exp %0h", tag, got, exp); end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_dot"}, 64'(dot != '0), 64'd0);
      chk({tag, "_valid"}, 64'(dot_valid), 64'd0);
      chk({tag, "_session"}, 64'(session_id), 64'd0);
      chk({tag, "_drop"}, 64'(drop_cnt), 64'd0);
      chk({tag, "_overflow"}, 64'(overflow), 64'd0);
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1; meta_valid = 1'b0; data_valid = 1'b0; data_last = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < CH; c++) exp_q[c].delete();
      for (int w = 0; w < WN; w++) exp_sess[w] = '0;
      exp_drop = '0; cur_w = -1; mbeat = 0;
      check_zero(tag);
   endtask

   task automatic send_meta(input logic [31:0] ip, input logic [15:0] sess, input logic [15:0] len);
      logic ok; int budget;
      meta_valid = 1'b1;
      meta_data  = {8'h00, 16'h1234, ip, len, sess};
      ok = 1'b0; budget = 0;
      while (!ok && budget < 100) begin
         ok = meta_ready;
         @(negedge clk);
         budget++;
      end
      meta_valid = 1'b0;
      chk("meta_accept", 64'(ok), 64'd1);
      if (ok && len != 0) begin
         cur_w = lookup(ip);
         mbeat = 0;
         if (cur_w >= 0) exp_sess[cur_w] = sess;
      end
   endtask

   task automatic send_beat(input logic [PW-1:0] pay, input logic last, output int stalls);
      logic ok; int budget;
      data_valid = 1'b1;
      data_data  = {rand_pay(), pay};
      data_last  = last;
      ok = 1'b0; budget = 0; stalls = 0;
      while (!ok && budget < 200) begin
         ok = data_ready;
         @(negedge clk);
         budget++;
         if (!ok) stalls++;
      end
      data_valid = 1'b0; data_last = 1'b0;
      chk("beat_accept", 64'(ok), 64'd1);
      if (ok) begin
         if (cur_w >= 0) begin
            exp_q[cur_w*EN + mbeat].push_back(pay);
            mbeat = last ? 0 : (mbeat + 1) % EN;
         end else if (last) begin
            if (exp_drop != '1) exp_drop++;
         end
      end
   endtask

   task automatic send_pkt(input logic [31:0] ip, input logic [15:0] sess, input int nbeats,
                           output int stalls);
      int s;
      stalls = 0;
      send_meta(ip, sess, 16'(nbeats * 64));
      for (int b = 0; b < nbeats; b++) begin
         send_beat(rand_pay(), b == nbeats - 1, s);
         stalls += s;
      end
   endtask

   task automatic send_pattern_pkt(input logic [31:0] ip, input logic [15:0] sess);
      int s;
      send_meta(ip, sess, 16'd64);
      send_beat(pattern_pay(0), 1'b0, s);
      send_beat(pattern_pay(16), 1'b1, s);
   endtask

   initial begin
      int st, tot, hi, p0;
      ip_table   = {IP1, IP0};
      rd_gap     = 4'd0;
      meta_data  = '0;
      data_data  = '0;
      do_reset("reset");

      // Known workers, fixed lane pattern.
      p0 = npulse;
      send_pattern_pkt(IP1, 16'h1234);
      send_pattern_pkt(IP0, 16'h0042);
      repeat (10) @(negedge clk);
      chk("basic_pulses", 64'(npulse - p0), 64'd1);
      chk("basic_ch2_hold", 64'(dot[2*PW +: 64]), 64'h0000_0002_0000_0001);
      chk("basic_ch3_hold", 64'(dot[3*PW +: 64]), 64'h0000_0012_0000_0011);
      chk("basic_valid_low", 64'(dot_valid), 64'd0);
      chk("session_w1", 64'(session_id[16 +: 16]), 64'(exp_sess[1]));
      chk("session_w0", 64'(session_id[0 +: 16]), 64'(exp_sess[0]));

      // Random traffic from both workers.
      for (int k = 0; k < 8; k++) begin
         send_pkt(($urandom_range(0, 1) == 1) ? IP1 : IP0, 16'($urandom()),
                  2 * $urandom_range(1, 3), st);
      end
      repeat (20) @(negedge clk);
      chk("random_drained", 64'(all_nonempty()), 64'd0);
      chk("random_session_w0", 64'(session_id[0 +: 16]), 64'(exp_sess[0]));
      chk("random_session_w1", 64'(session_id[16 +: 16]), 64'(exp_sess[1]));

      // Unknown sender: beats are swallowed with only the judge cycle of stall.
      p0 = npulse;
      send_pkt(IPX, 16'h0bad, 3, st);
      repeat (10) @(negedge clk);
      chk("drop_stalls", 64'(st), 64'd1);
      chk("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
      chk("drop_no_pulse", 64'(npulse - p0), 64'd0);
      chk("drop_overflow", 64'(overflow), 64'd0);

      // Zero-length metadata never leaves idle.
      send_meta(IP1, 16'h7777, 16'd0);
      chk("len0_meta_ready", 64'(meta_ready), 64'd1);
      chk("len0_data_ready", 64'(data_ready), 64'd0);
      chk("len0_session", 64'(session_id[16 +: 16]), 64'(exp_sess[1]));
      chk("len0_drop", 64'(drop_cnt), 64'(exp_drop));

      // Fill ch0 to the almost-full mark with single-beat packets.
      do_reset("reset_fill");
      tot = 0; p0 = npulse;
      for (int k = 0; k < 62; k++) begin
         send_pkt(IP0, 16'(k), 1, st);
         tot += st;
      end
      chk("fill_stalls", 64'(tot), 64'd62);
      send_meta(IP0, 16'h0063, 16'd64);
      data_valid = 1'b1; data_last = 1'b1; hi = 0;
      repeat (8) begin
         if (data_ready) hi++;
         @(negedge clk);
      end
      data_valid = 1'b0; data_last = 1'b0;
      chk("fill_ready_low", 64'(hi), 64'd0);
      chk("fill_overflow", 64'(overflow), 64'd0);
      chk("fill_no_pulse", 64'(npulse - p0), 64'd0);

      // Abandon the stuck packet, then reset in the middle of a packet at beat_idx 1.
      do_reset("reset_stuck");
      send_meta(IP1, 16'h0abc, 16'd192);
      send_beat(rand_pay(), 1'b0, st);
      do_reset("reset_mid");
      p0 = npulse;
      send_pattern_pkt(IP1, 16'h0101);
      send_pattern_pkt(IP0, 16'h0202);
      repeat (10) @(negedge clk);
      chk("post_reset_pulses", 64'(npulse - p0), 64'd1);
      chk("post_reset_ch2", 64'(dot[2*PW +: 64]), 64'h0000_0002_0000_0001);

      // Deep ch0 alone does not drain; feeding the rest resumes draining.
      p0 = npulse;
      for (int k = 0; k < 20; k++) send_pkt(IP0, 16'(k), 1, st);
      repeat (10) @(negedge clk);
      chk("one_ch_no_pulse", 64'(npulse - p0), 64'd0);
      send_pkt(IP1, 16'h0303, 2, st);
      send_pkt(IP0, 16'h0404, 2, st);
      repeat (10) @(negedge clk);
      chk("resume_pulses", 64'(npulse - p0), 64'd1);
      chk("resume_drained", 64'(all_nonempty()), 64'd0);

      // Programmable gap: round period 3 + rd_gap.
      rd_gap = 4'd5;
      do_reset("reset_gap");
      for (int k = 0; k < 4; k++) send_pkt(IP0, 16'(k), 2, st);
      p0 = npulse;
      pulse_cyc.delete();
      send_pkt(IP1, 16'h0505, 8, st);
      repeat (60) @(negedge clk);
      chk("gap_pulses", 64'(npulse - p0), 64'd4);
      for (int i = 1; i < pulse_cyc.size(); i++)
         chk("gap_spacing", 64'(pulse_cyc[i] - pulse_cyc[i-1]), 64'd8);
      chk("gap_drained", 64'(all_nonempty()), 64'd0);
      chk("gap_overflow", 64'(overflow), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
